// File: rtl/serial_adder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_adder_if : start/operand request and busy/done/result bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             C_out;

  modport master (output start, A, B, C_in, input busy, done, Sum, C_out);
  modport slave  (input start, A, B, C_in, output busy, done, Sum, C_out);
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_adder : LSB-first bit-serial adder around one Full_Add cell
// Rev 1.0
// ----------------------------------------------------------------------------
module Full_Add (
  input  wire logic I1,
  input  wire logic I2,
  input  wire logic C_in,
  output logic      S,
  output logic      C_out
);
  assign S     = I1 ^ I2 ^ C_in;
  assign C_out = (I1 & I2) | (C_in & (I1 ^ I2));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  serial_adder_if.slave bus
);
  localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_s_sr;
  logic [WIDTH-1:0] w_s_nxt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cy;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_c;

  Full_Add u_fa (
    .I1    (r_a_sr[0]),
    .I2    (r_b_sr[0]),
    .C_in  (r_cy),
    .S     (w_s),
    .C_out (w_c)
  );

  assign w_last  = (r_cnt == C_LAST);
  assign w_s_nxt = {w_s, (WIDTH-1)'(r_s_sr >> 1)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // A start seen in the single DONE cycle chains straight into RUN.
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_s_sr <= '0;
      r_cy   <= 1'b0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_load) begin
      r_a_sr <= bus.A;
      r_b_sr <= bus.B;
      r_cy   <= bus.C_in;
      r_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sr <= r_a_sr >> 1;
      r_b_sr <= r_b_sr >> 1;
      r_s_sr <= w_s_nxt;
      r_cy   <= w_c;
      r_cnt  <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_s_nxt;
        r_cout <= w_c;
      end
    end
  end

  assign bus.busy  = (r_state == S_RUN);
  assign bus.done  = (r_state == S_DONE);
  assign bus.Sum   = r_sum;
  assign bus.C_out = r_cout;
endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_serial_adder : randomized and directed checks against an arithmetic model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_serial_adder;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(2)) bus2 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_adder #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {8'd0, c};
  endfunction

  // Presents one request for a single edge, then scrambles the operand pins
  // and waits (bounded) for busy to drop; leaves the caller in the DONE cycle.
  task automatic drive_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           output int nbusy, output bit got_done);
    @(negedge clk);
    bus8.start = 1'b1; bus8.A = a; bus8.B = b; bus8.C_in = cin;
    @(negedge clk);
    bus8.start = 1'b0; bus8.A = 8'($urandom); bus8.B = 8'($urandom); bus8.C_in = 1'($urandom);
    nbusy = 0;
    while (bus8.busy === 1'b1 && nbusy < 40) begin
      nbusy++;
      @(negedge clk);
    end
    got_done = (bus8.done === 1'b1);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus8.busy, bus8.done, bus8.C_out, bus8.Sum} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b C_out=%b Sum=%h, expected all 0",
               bus8.busy, bus8.done, bus8.C_out, bus8.Sum);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", bus8.busy, bus8.done);
      end
    end
  endtask

  task automatic test_basic;
    logic [7:0] ta [2] = '{8'h5A, 8'h00};
    logic [7:0] tb [2] = '{8'h3C, 8'h00};
    logic       tc [2] = '{1'b1, 1'b0};
    logic [8:0] exp_r;
    int nb; bit gd;
    for (int k = 0; k < 2; k++) begin
      exp_r = ref8(ta[k], tb[k], tc[k]);
      drive_op8(ta[k], tb[k], tc[k], nb, gd);
      checks++;
      if (nb != 8) begin
        errors++;
        $display("FAIL basic_busy_len: got %0d cycles, expected 8", nb);
      end
      checks++;
      if (!gd) begin
        errors++;
        $display("FAIL basic_done: got done=%b, expected 1", bus8.done);
      end
      checks++;
      if ({bus8.C_out, bus8.Sum} !== exp_r) begin
        errors++;
        $display("FAIL basic_sum: got %h, expected %h", {bus8.C_out, bus8.Sum}, exp_r);
      end
      @(negedge clk);
      checks++;
      if (bus8.done !== 1'b0 || {bus8.C_out, bus8.Sum} !== exp_r) begin
        errors++;
        $display("FAIL basic_done_pulse: got done=%b result=%h, expected 0 %h",
                 bus8.done, {bus8.C_out, bus8.Sum}, exp_r);
      end
    end
  endtask

  task automatic test_carry;
    logic [7:0] tb [2] = '{8'h00, 8'hFF};
    logic [8:0] exp_r;
    int nb; bit gd;
    for (int k = 0; k < 2; k++) begin
      exp_r = ref8(8'hFF, tb[k], 1'b1);
      drive_op8(8'hFF, tb[k], 1'b1, nb, gd);
      checks++;
      if (!gd || {bus8.C_out, bus8.Sum} !== exp_r) begin
        errors++;
        $display("FAIL carry_sum: got done=%b result=%h, expected 1 %h",
                 bus8.done, {bus8.C_out, bus8.Sum}, exp_r);
      end
    end
  endtask

  task automatic test_start_busy;
    int ndone = 0;
    logic [8:0] seen = 9'h1FF;
    @(negedge clk);
    bus8.start = 1'b1; bus8.A = 8'h01; bus8.B = 8'h01; bus8.C_in = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin
        bus8.start = 1'b1; bus8.A = 8'hAA; bus8.B = 8'h55;
      end else begin
        bus8.start = 1'b0;
      end
      if (bus8.done === 1'b1) begin
        ndone++;
        seen = {bus8.C_out, bus8.Sum};
      end
      @(negedge clk);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL busy_start_pulses: got %0d done pulses, expected 1", ndone);
    end
    checks++;
    if (seen !== 9'h002) begin
      errors++;
      $display("FAIL busy_start_sum: got %h, expected 002", seen);
    end
    checks++;
    if (bus8.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_queued: got busy=%b, expected 0", bus8.busy);
    end
  endtask

  task automatic test_back_to_back;
    int nb; bit gd; int t;
    drive_op8(8'h33, 8'h44, 1'b0, nb, gd);
    checks++;
    if (!gd || {bus8.C_out, bus8.Sum} !== ref8(8'h33, 8'h44, 1'b0)) begin
      errors++;
      $display("FAIL b2b_first: got done=%b result=%h, expected 1 077",
               bus8.done, {bus8.C_out, bus8.Sum});
    end
    bus8.start = 1'b1; bus8.A = 8'h10; bus8.B = 8'h20; bus8.C_in = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    checks++;
    if (bus8.busy !== 1'b1 || bus8.done !== 1'b0 || bus8.Sum !== 8'h77) begin
      errors++;
      $display("FAIL b2b_rearm: got busy=%b done=%b Sum=%h, expected 1 0 77",
               bus8.busy, bus8.done, bus8.Sum);
    end
    t = 1;
    while (bus8.done !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t != 9) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles between results, expected 9", t);
    end
    checks++;
    if ({bus8.C_out, bus8.Sum} !== ref8(8'h10, 8'h20, 1'b0)) begin
      errors++;
      $display("FAIL b2b_second: got %h, expected 030", {bus8.C_out, bus8.Sum});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int nb; bit gd; int nhigh = 0;
    @(negedge clk);
    bus8.start = 1'b1; bus8.A = 8'hC3; bus8.B = 8'h5A; bus8.C_in = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.busy, bus8.done, bus8.C_out, bus8.Sum} !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset_async: got busy=%b done=%b C_out=%b Sum=%h, expected all 0",
               bus8.busy, bus8.done, bus8.C_out, bus8.Sum);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) nhigh++;
    end
    checks++;
    if (nhigh != 0) begin
      errors++;
      $display("FAIL mid_reset_discard: got %0d busy/done cycles, expected 0", nhigh);
    end
    drive_op8(8'h7F, 8'h01, 1'b1, nb, gd);
    checks++;
    if (!gd || nb != 8 || {bus8.C_out, bus8.Sum} !== ref8(8'h7F, 8'h01, 1'b1)) begin
      errors++;
      $display("FAIL mid_reset_recover: got done=%b busy_len=%0d result=%h, expected 1 8 %h",
               bus8.done, nb, {bus8.C_out, bus8.Sum}, ref8(8'h7F, 8'h01, 1'b1));
    end
  endtask

  task automatic test_random;
    logic [7:0] a, b; logic c; logic [8:0] exp_r;
    int nb; bit gd;
    for (int k = 0; k < 24; k++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      exp_r = ref8(a, b, c);
      drive_op8(a, b, c, nb, gd);
      checks++;
      if (!gd || nb != 8 || {bus8.C_out, bus8.Sum} !== exp_r) begin
        errors++;
        $display("FAIL random_%0d: %h+%h+%b got done=%b busy_len=%0d result=%h, expected 1 8 %h",
                 k, a, b, c, bus8.done, nb, {bus8.C_out, bus8.Sum}, exp_r);
      end
    end
  endtask

  task automatic test_w2_sweep;
    logic [4:0] vv; logic [1:0] a, b; logic c; logic [2:0] exp_r; int nb;
    for (int v = 0; v < 32; v++) begin
      vv = 5'(v);
      a = vv[4:3]; b = vv[2:1]; c = vv[0];
      exp_r = {1'b0, a} + {1'b0, b} + {2'b00, c};
      @(negedge clk);
      bus2.start = 1'b1; bus2.A = a; bus2.B = b; bus2.C_in = c;
      @(negedge clk);
      bus2.start = 1'b0; bus2.A = 2'($urandom); bus2.B = 2'($urandom);
      nb = 0;
      while (bus2.busy === 1'b1 && nb < 10) begin
        nb++;
        @(negedge clk);
      end
      checks++;
      if (bus2.done !== 1'b1 || nb != 2 || {bus2.C_out, bus2.Sum} !== exp_r) begin
        errors++;
        $display("FAIL w2_%0d: %0d+%0d+%0d got done=%b busy_len=%0d result=%0d, expected 1 2 %0d",
                 v, a, b, c, bus2.done, nb, {bus2.C_out, bus2.Sum}, exp_r);
      end
    end
  endtask

  initial begin
    bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.C_in = 1'b0;
    bus2.start = 1'b0; bus2.A = '0; bus2.B = '0; bus2.C_in = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_w2_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end
endmodule
`default_nettype wire
